particle_feeder: RTL and testbench
==================================

PARTICLE_FEEDER -- requirements
Module: particle_feeder

Interface
REQ-001 SHALL have parameter NUM_PARTICLES, default 256, meaning particles read per frame (1..4096).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning particle-buffer read latency in cycles (1..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch slots (power of two, >= 2).
REQ-004 SHALL have port clk_in, input, 1, meaning the single clock, rising edge; all logic is in this domain.
REQ-005 SHALL have port rst_in, input, 1, meaning the asynchronous, active-low reset.
REQ-006 SHALL have port frame_start_in, input, 1, meaning a one-cycle pulse that starts a frame pass.
REQ-007 SHALL have port mem_addr_out, output, clog2(NUM_PARTICLES), meaning the particle-buffer read address.
REQ-008 SHALL have port mem_rd_out, output, 1, meaning the read strobe for the particle buffer.
REQ-009 SHALL have port mem_data_in, input, 48, meaning {x[47:32], y[31:16], z[15:0]}, valid RD_LATENCY cycles after the strobe.
REQ-010 SHALL have port render_ready_in, input, 1, meaning the downstream render stage can accept a particle.
REQ-011 SHALL have ports f_x_out, f_y_out and f_z_out, output, 16 each, meaning the particle coordinates.
REQ-012 SHALL have port data_valid_out, output, 1, meaning the f_*_out ports hold a valid particle.
REQ-013 SHALL have port busy_out, output, 1, meaning a frame pass is in progress.
REQ-014 SHALL have port frame_done_out, output, 1, meaning a one-cycle pulse after the last particle is accepted.
REQ-015 SHALL have port overrun_out, output, 1, meaning a sticky flag set when a frame_start_in arrives while busy.

Function
REQ-016 SHALL define a transfer as data_valid_out=1 and render_ready_in=1 on the same rising edge.
REQ-017 SHALL hold f_*_out and data_valid_out stable while data_valid_out=1 and render_ready_in=0.
REQ-018 SHALL use the states IDLE, RUN and DRAIN.
REQ-019 SHALL move from IDLE to RUN on frame_start_in=1, clearing the read index and the transfer count to 0.
REQ-020 SHALL issue reads in RUN: mem_rd_out=1 with mem_addr_out set to the read index, then increment the index.
REQ-021 SHALL issue a read only when (occupancy + in-flight reads) < FIFO_DEPTH, counting a transfer in the same cycle as freeing one slot.
REQ-022 SHALL track in-flight reads with an RD_LATENCY-deep valid shift register and write mem_data_in into the FIFO when a return arrives.
REQ-023 SHALL sustain one read and one transfer per cycle when render_ready_in is held at 1 (full throughput).
REQ-024 SHALL make the FIFO head visible on the outputs so that the first data_valid_out rises RD_LATENCY+1 cycles after the first mem_rd_out.
REQ-025 SHALL move from RUN to DRAIN after the read at index NUM_PARTICLES-1 is issued, with no further reads and no address wrap.
REQ-026 SHALL, in DRAIN, pulse frame_done_out for one cycle on the cycle after the NUM_PARTICLES-th transfer, then enter IDLE with busy_out=0.
REQ-027 SHALL keep busy_out=1 exactly in RUN and DRAIN.
REQ-028 SHALL ignore frame_start_in while busy, with no restart and no state change, and set overrun_out=1.
REQ-029 SHALL clear overrun_out only by reset.
REQ-030 SHALL accept frame_start_in in the same cycle that frame_done_out is pulsed, because the state is IDLE then; it is not an overrun.
REQ-031 SHALL never overflow the FIFO, never write to a full FIFO and never drop a returned word; simultaneous push and pop keep the occupancy unchanged.
REQ-032 SHALL never assert data_valid_out while the FIFO is empty.
REQ-033 SHALL pass mem_data_in to the outputs unmodified, with no arithmetic on the coordinates.

Reset
REQ-034 SHALL, while rst_in=0, immediately force state IDLE, mem_rd_out=0, mem_addr_out=0, data_valid_out=0, busy_out=0, frame_done_out=0, overrun_out=0, f_*_out=0, FIFO empty and the in-flight register cleared.
REQ-035 SHALL discard any pass that reset interrupts, including in-flight returns arriving after release, and emit no frame_done_out.
REQ-036 SHALL need a fresh frame_start_in after reset release before any read.

Verification
REQ-037 SHALL cover: NUM_PARTICLES=8, RD_LATENCY=2, ready held at 1, memory word i = {i, i+100, i+200} -> 8 consecutive transfers x=0..7, y=100..107, z=200..207; first valid 3 cycles after first mem_rd_out; frame_done_out one cycle after the 8th transfer.
REQ-038 SHALL cover: ready toggling 1,0,0,1 repeatedly -> outputs stable while stalled, in-flight + occupancy never > 4, all 8 particles in order with no duplicates.
REQ-039 SHALL cover: ready held at 0 for 20 cycles after start -> exactly 4 reads issued, then mem_rd_out=0 until ready rises.
REQ-040 SHALL cover: second frame_start_in at the 3rd transfer -> overrun_out=1 and held; the pass still ends after 8 transfers with one frame_done_out.
REQ-041 SHALL cover: rst_in=0 asynchronously mid-pass with 2 reads in flight -> all outputs 0 before the next edge; after release no valid and no done until a new start; the next pass yields x=0..7.
REQ-042 SHALL cover: frame_start_in coincident with frame_done_out -> the new pass starts, overrun_out stays 0 and mem_addr_out=0 the next cycle.

Source files
------------

// File: rtl/particle_feeder.sv
// Prefetching particle-buffer reader: read strobe to first valid is RD_LATENCY+1 cycles, one particle per cycle.
// Reads pause once the FIFO plus in-flight reads would reach FIFO_DEPTH; the output is held while render_ready_in is low.
module pf_fifo #(
   parameter int   WIDTH = 48,
   parameter int   DEPTH = 4,
   localparam int  PW    = $clog2(DEPTH),
   localparam int  CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] slot [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push_vld & ((count != CW'(DEPTH)) | do_pop);
   assign head_dat = slot[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      end else begin
         if (do_push) begin
            slot[wr_ptr] <= push_dat;
            wr_ptr       <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
      end
   end
endmodule

// Frame-pass sequencer: IDLE -> RUN (issue reads) -> DRAIN (wait for last transfer) -> IDLE.
// Output is the FIFO head, so data and valid hold by construction while the renderer stalls.
module particle_feeder #(
   parameter int  NUM_PARTICLES = 256,
   parameter int  RD_LATENCY    = 2,
   parameter int  FIFO_DEPTH    = 4,
   localparam int AW = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          frame_start_in,
   output logic [AW-1:0] mem_addr_out,
   output logic          mem_rd_out,
   input  logic [47:0]   mem_data_in,
   input  logic          render_ready_in,
   output logic [15:0]   f_x_out,
   output logic [15:0]   f_y_out,
   output logic [15:0]   f_z_out,
   output logic          data_valid_out,
   output logic          busy_out,
   output logic          frame_done_out,
   output logic          overrun_out
);
   localparam int CW = $clog2(NUM_PARTICLES + 1);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [CW-1:0]         rd_idx;
   logic [CW-1:0]         xfer_cnt;
   logic [RD_LATENCY-1:0] ret_sr;
   logic [OW-1:0]         occ;
   logic [47:0]           head_dat;
   logic                  fifo_empty;
   logic                  xfer;
   logic                  can_issue;
   logic [SW-1:0]         inflight;
   logic [SW-1:0]         pending;

   assign data_valid_out              = ~fifo_empty;
   assign xfer                        = data_valid_out & render_ready_in;
   assign {f_x_out, f_y_out, f_z_out} = head_dat;

   pf_fifo #(.WIDTH(48), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk_in),
      .rst_n    (rst_in),
      .push_vld (ret_sr[RD_LATENCY-1]),
      .push_dat (mem_data_in),
      .pop      (xfer),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .count    (occ)
   );

   // In-flight includes the strobe on the bus now; a transfer this cycle frees its slot.
   always_comb begin
      inflight = SW'(mem_rd_out);
      for (int k = 0; k < RD_LATENCY; k++) inflight = inflight + SW'(ret_sr[k]);
      pending   = SW'(occ) + inflight - SW'(xfer);
      can_issue = (state == RUN) && (pending < SW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ret_sr <= '0;
      end else begin
         ret_sr[0] <= mem_rd_out;
         for (int k = 1; k < RD_LATENCY; k++) ret_sr[k] <= ret_sr[k-1];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         rd_idx         <= '0;
         xfer_cnt       <= '0;
         mem_addr_out   <= '0;
         mem_rd_out     <= 1'b0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         frame_done_out <= 1'b0;
         mem_rd_out     <= 1'b0;
         if (xfer) xfer_cnt <= xfer_cnt + CW'(1);
         if (state != IDLE && frame_start_in) overrun_out <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_start_in) begin
                  state        <= RUN;
                  busy_out     <= 1'b1;
                  rd_idx       <= '0;
                  xfer_cnt     <= '0;
                  mem_addr_out <= '0;
               end
            end
            RUN: begin
               if (can_issue) begin
                  mem_rd_out   <= 1'b1;
                  mem_addr_out <= rd_idx[AW-1:0];
                  rd_idx       <= rd_idx + CW'(1);
                  if (rd_idx == CW'(NUM_PARTICLES - 1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (xfer && xfer_cnt == CW'(NUM_PARTICLES - 1)) begin
                  frame_done_out <= 1'b1;
                  busy_out       <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_particle_feeder.sv
// Scoreboarded bench for particle_feeder: 8 particles, read latency 2, 4 prefetch slots.
// Stimulus pushes expected particles; a negedge monitor checks transfers, stalls, addresses and done timing.
module tb_particle_feeder;
   localparam int NP    = 8;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic        clk_in          = 1'b0;
   logic        rst_in          = 1'b1;
   logic        frame_start_in  = 1'b0;
   logic        render_ready_in = 1'b0;
   logic [47:0] mem_data_in     = '0;
   logic [2:0]  mem_addr_out;
   logic        mem_rd_out;
   logic [15:0] f_x_out, f_y_out, f_z_out;
   logic        data_valid_out, busy_out, frame_done_out, overrun_out;

   always #5 clk_in = ~clk_in;

   particle_feeder #(.NUM_PARTICLES(NP), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .frame_start_in  (frame_start_in),
      .mem_addr_out    (mem_addr_out),
      .mem_rd_out      (mem_rd_out),
      .mem_data_in     (mem_data_in),
      .render_ready_in (render_ready_in),
      .f_x_out         (f_x_out),
      .f_y_out         (f_y_out),
      .f_z_out         (f_z_out),
      .data_valid_out  (data_valid_out),
      .busy_out        (busy_out),
      .frame_done_out  (frame_done_out),
      .overrun_out     (overrun_out)
   );

   int          checks = 0;
   int          errors = 0;
   logic [47:0] exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] word(input logic [2:0] a);
      int i = int'(a);
      return {16'(i), 16'(i + 100), 16'(i + 200)};
   endfunction

   task automatic push_pass();
      for (int i = 0; i < NP; i++) exp_q.push_back(word(3'(i)));
   endtask

   task automatic pulse_start();
      @(posedge clk_in); #1 frame_start_in = 1'b1;
      @(posedge clk_in); #1 frame_start_in = 1'b0;
   endtask

   task automatic wait_done(input int mode, output bit seen);
      logic [3:0] pat = 4'b1001;
      seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(posedge clk_in); #1;
         render_ready_in = (mode == 0) ? 1'b1 : pat[k % 4];
         if (frame_done_out) seen = 1'b1;
      end
   endtask

   // Memory model: word for the address strobed in cycle t is presented through the edge ending cycle t+2.
   logic       a1_v = 1'b0, a2_v = 1'b0;
   logic [2:0] a1 = '0, a2 = '0;
   always @(negedge clk_in) begin
      mem_data_in = a2_v ? word(a2) : 48'hdead_beef_cafe;
      a2_v = a1_v;
      a2   = a1;
      a1_v = mem_rd_out;
      a1   = mem_addr_out;
   end

   int          rd_cnt = 0, tx_cnt = 0, xfers = 0, done_cnt = 0, exp_addr = 0;
   bit          done_due = 1'b0, prev_stall = 1'b0;
   logic [47:0] prev_dat = '0;
   logic [47:0] exp_dat;

   always @(negedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_cnt = 0; tx_cnt = 0; xfers = 0; exp_addr = 0;
         done_due = 1'b0; prev_stall = 1'b0;
         exp_q.delete();
      end else begin
         if (done_due || frame_done_out) begin
            check("frame_done_timing", frame_done_out, done_due);
            if (frame_done_out) done_cnt++;
            if (done_due) check("busy_after_done", busy_out, 0);
            done_due = 1'b0;
         end
         if (frame_start_in && !busy_out) begin
            exp_addr = 0;
            xfers    = 0;
         end
         if (prev_stall)
            check("stall_hold", {data_valid_out, f_x_out, f_y_out, f_z_out}, {1'b1, prev_dat});
         if (mem_rd_out) begin
            rd_cnt++;
            check("rd_addr", mem_addr_out, exp_addr);
            exp_addr++;
            check("outstanding_le_depth", (rd_cnt - tx_cnt) <= DEPTH, 1);
         end
         if (data_valid_out && render_ready_in) begin
            if (exp_q.size() == 0) begin
               check("unexpected_transfer", 1, 0);
            end else begin
               exp_dat = exp_q.pop_front();
               check("particle", {f_x_out, f_y_out, f_z_out}, exp_dat);
            end
            tx_cnt++;
            xfers++;
            if (xfers == NP) done_due = 1'b1;
         end
         prev_stall = data_valid_out && !render_ready_in;
         prev_dat   = {f_x_out, f_y_out, f_z_out};
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, wanted finished");
      $fatal(1, "timeout");
   end

   initial begin
      int fr, fv, fd, n, v, dn, d0;
      bit seen;

      #1 rst_in = 1'b0;
      #2;
      check("reset_outputs", {mem_rd_out, mem_addr_out, data_valid_out, busy_out, frame_done_out,
                              overrun_out, f_x_out, f_y_out, f_z_out}, 0);
      #10 rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check("no_read_before_start", rd_cnt, 0);

      // Full throughput pass.
      push_pass();
      render_ready_in = 1'b1;
      pulse_start();
      check("busy_in_run", busy_out, 1);
      check("start_addr", mem_addr_out, 0);
      fr = -1; fv = -1; fd = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_in);
         if (mem_rd_out && fr < 0) fr = k;
         if (data_valid_out && fv < 0) fv = k;
         if (frame_done_out) begin
            fd = k;
            break;
         end
      end
      check("first_valid_latency", fv - fr, LAT + 1);
      check("done_after_first_valid", fd - fv, NP);
      check("queue_drained_1", exp_q.size(), 0);
      @(posedge clk_in); #1;
      check("idle_after_done", busy_out, 0);

      // Ready toggling 1,0,0,1.
      push_pass();
      pulse_start();
      wait_done(1, seen);
      check("toggle_pass_done", seen, 1);
      check("queue_drained_2", exp_q.size(), 0);

      // Ready low after start: reads stop at the slot limit.
      push_pass();
      render_ready_in = 1'b0;
      pulse_start();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_in);
         if (mem_rd_out) n++;
      end
      check("reads_while_stalled", n, DEPTH);
      check("no_read_when_full", mem_rd_out, 0);
      check("valid_while_stalled", data_valid_out, 1);
      wait_done(0, seen);
      check("stall_pass_done", seen, 1);
      check("queue_drained_3", exp_q.size(), 0);

      // Start while busy at the third transfer.
      push_pass();
      render_ready_in = 1'b1;
      pulse_start();
      for (int k = 0; k < 50; k++) begin
         @(posedge clk_in); #1;
         if (xfers >= 2) break;
      end
      d0 = done_cnt;
      frame_start_in = 1'b1;
      @(posedge clk_in); #1 frame_start_in = 1'b0;
      check("overrun_set", overrun_out, 1);
      check("busy_kept", busy_out, 1);
      wait_done(0, seen);
      check("overrun_pass_done", seen, 1);
      repeat (4) @(posedge clk_in);
      #1;
      check("single_done", done_cnt - d0, 1);
      check("overrun_sticky", overrun_out, 1);
      check("queue_drained_4", exp_q.size(), 0);

      // Asynchronous reset with two reads in flight.
      push_pass();
      pulse_start();
      repeat (3) @(negedge clk_in);
      #1 check("two_in_flight", rd_cnt - tx_cnt, 2);
      #1 rst_in = 1'b0;
      #1 check("async_reset_outputs", {mem_rd_out, mem_addr_out, data_valid_out, busy_out, frame_done_out,
                                       overrun_out, f_x_out, f_y_out, f_z_out}, 0);
      #1 rst_in = 1'b1;
      n = 0; v = 0; dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_in);
         if (mem_rd_out) n++;
         if (data_valid_out) v++;
         if (frame_done_out) dn++;
      end
      check("no_read_after_reset", n, 0);
      check("no_valid_after_reset", v, 0);
      check("no_done_after_reset", dn, 0);
      push_pass();
      pulse_start();
      wait_done(0, seen);
      check("post_reset_pass_done", seen, 1);
      check("queue_drained_5", exp_q.size(), 0);

      // Start coincident with frame_done_out.
      push_pass();
      pulse_start();
      wait_done(0, seen);
      check("first_of_pair_done", seen, 1);
      push_pass();
      frame_start_in = 1'b1;
      @(posedge clk_in); #1 frame_start_in = 1'b0;
      check("restart_busy", busy_out, 1);
      check("restart_addr", mem_addr_out, 0);
      check("no_overrun_on_done_start", overrun_out, 0);
      wait_done(0, seen);
      check("second_of_pair_done", seen, 1);
      repeat (2) @(posedge clk_in);
      #1;
      check("overrun_still_clear", overrun_out, 0);
      check("queue_drained_6", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
